// File: rtl/button_pulse_gen.sv
// -----------------------------------------------------------------------------
// button_pulse_gen
//   Conditions one raw pushbutton input into a debounced level plus
//   single-cycle press/release strobes. Pipeline: 2-FF synchronizer ->
//   debounce FSM with a stability counter -> registered strobe outputs.
//
//   Optional feature (macro BUTTON_AUTOREPEAT_EN): while the button stays
//   pressed, p_b_press re-fires REPEAT_DELAY cycles after the initial press
//   strobe and then every REPEAT_RATE cycles. Without the macro the hold
//   counter does not exist and each accepted press gives exactly one strobe.
//
// Ports
//   clk          in   system clock, rising edge
//   rst_a        in   asynchronous active-high reset
//   p_b          in   raw, asynchronous, bouncing button input
//   p_b_level    out  debounced level, 1 = pressed
//   p_b_press    out  one-cycle strobe on accepted press (and each repeat)
//   p_b_release  out  one-cycle strobe on accepted release
// -----------------------------------------------------------------------------
module button_pulse_gen #(
    parameter int DB_CYCLES    = 500000,
    parameter int ACTIVE_LOW   = 0,
    parameter int REPEAT_DELAY = 25000000,
    parameter int REPEAT_RATE  = 5000000
) (
    input  logic clk,
    input  logic rst_a,
    input  logic p_b,
    output logic p_b_level,
    output logic p_b_press,
    output logic p_b_release
);

    // Counter is sized for the largest count it must reach, plus one bit.
`ifdef BUTTON_AUTOREPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int MAX_CNT = (REP_MAX > DB_CYCLES) ? REP_MAX : DB_CYCLES;
`else
    localparam int MAX_CNT = DB_CYCLES;
`endif
    localparam int CNT_W = $clog2(MAX_CNT) + 1;

    localparam logic             INV     = (ACTIVE_LOW != 0);
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_SAT = '1;
`ifdef BUTTON_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] DLY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RATE_LAST = CNT_W'(REPEAT_RATE - 1);
`endif

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             s1_q, s2_q;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
`ifdef BUTTON_AUTOREPEAT_EN
    logic [CNT_W-1:0] hold_q, hold_d;
    // rep_q: 0 while waiting out REPEAT_DELAY, 1 once in the REPEAT_RATE phase
    logic             rep_q, rep_d;
`endif

    // Saturating increment so the counter can never wrap.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_SAT) ? v : v + 1'b1;
    endfunction

    // Synchronizer: inversion happens before the first flop so the reset
    // value (0) is always the inactive level.
    always_ff @(posedge clk or posedge rst_a) begin
        if (rst_a) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= p_b ^ INV;
            s2_q <= s1_q;
        end
    end

    always_ff @(posedge clk or posedge rst_a) begin
        if (rst_a) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
`ifdef BUTTON_AUTOREPEAT_EN
            hold_q    <= '0;
            rep_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
`ifdef BUTTON_AUTOREPEAT_EN
            hold_q    <= hold_d;
            rep_q     <= rep_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
`ifdef BUTTON_AUTOREPEAT_EN
        hold_d    = '0;
        rep_d     = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (s2_q) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!s2_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    press_d = 1'b1;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end
            PRESSED: begin
                if (!s2_q) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end else begin
`ifdef BUTTON_AUTOREPEAT_EN
                    // Hold counter restarts at 0 after every repeat strobe;
                    // the phase flag picks which period it is measured against.
                    rep_d  = rep_q;
                    hold_d = sat_inc(hold_q);
                    if ((!rep_q && hold_q == DLY_LAST) || (rep_q && hold_q == RATE_LAST)) begin
                        press_d = 1'b1;
                        hold_d  = '0;
                        rep_d   = 1'b1;
                    end
`endif
                end
            end
            RELEASE_WAIT: begin
                if (s2_q) begin
                    // Bounce back: stay pressed, no strobe, repeat timing restarts.
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign p_b_level   = level_q;
    assign p_b_press   = press_q;
    assign p_b_release = release_q;

endmodule

// File: tb/tb_button_pulse_gen.sv
// -----------------------------------------------------------------------------
// tb_button_pulse_gen
//   Directed bench for button_pulse_gen with DB_CYCLES=4, REPEAT_DELAY=10,
//   REPEAT_RATE=3. dut_h is active-high, dut_l is active-low. Edge 0 is the
//   first clock edge that samples a new p_b value; an accepted press/release
//   shows its strobe just after edge 6.
// -----------------------------------------------------------------------------
module tb_button_pulse_gen;

    logic clk = 1'b0;
    logic rst_a;
    logic pb_h, pb_l;
    logic lvl_h, prs_h, rel_h;
    logic lvl_l, prs_l, rel_l;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    button_pulse_gen #(.DB_CYCLES(4), .ACTIVE_LOW(0), .REPEAT_DELAY(10), .REPEAT_RATE(3)) dut_h (
        .clk(clk), .rst_a(rst_a), .p_b(pb_h),
        .p_b_level(lvl_h), .p_b_press(prs_h), .p_b_release(rel_h)
    );

    button_pulse_gen #(.DB_CYCLES(4), .ACTIVE_LOW(1), .REPEAT_DELAY(10), .REPEAT_RATE(3)) dut_l (
        .clk(clk), .rst_a(rst_a), .p_b(pb_l),
        .p_b_level(lvl_l), .p_b_press(prs_l), .p_b_release(rel_l)
    );

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge and settle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk3(input string tag, input logic l, input logic p, input logic r,
                        input logic el, input logic ep, input logic er);
        chk({tag, ".level"},   l, el);
        chk({tag, ".press"},   p, ep);
        chk({tag, ".release"}, r, er);
    endtask

    initial begin
        logic exp_p;

        // ---- reset state, before any clock edge ----
        rst_a = 1'b1;
        pb_h  = 1'b0;
        pb_l  = 1'b1;
        #1;
        chk3("reset_h", lvl_h, prs_h, rel_h, 1'b0, 1'b0, 1'b0);
        chk3("reset_l", lvl_l, prs_l, rel_l, 1'b0, 1'b0, 1'b0);
        step();
        step();
        rst_a = 1'b0;

        // ---- idle after reset: no strobes (active-low idle at 1 included) ----
        for (int e = 0; e < 8; e++) begin
            step();
            chk3($sformatf("idle_h e%0d", e), lvl_h, prs_h, rel_h, 1'b0, 1'b0, 1'b0);
            chk3($sformatf("idle_l e%0d", e), lvl_l, prs_l, rel_l, 1'b0, 1'b0, 1'b0);
        end

        // ---- case 1: clean press ----
        pb_h = 1'b1;
        for (int e = 0; e < 10; e++) begin
            step();
            chk3($sformatf("press e%0d", e), lvl_h, prs_h, rel_h, (e >= 6), (e == 6), 1'b0);
        end

        // ---- case 3: clean release ----
        pb_h = 1'b0;
        for (int e = 0; e < 10; e++) begin
            step();
            chk3($sformatf("release e%0d", e), lvl_h, prs_h, rel_h, (e < 6), 1'b0, (e == 6));
        end

        // ---- case 2: bounce reject (3 high, 2 low, 3 high, then low) ----
        for (int i = 0; i < 18; i++) begin
            pb_h = (i < 3) || (i >= 5 && i < 8);
            step();
            chk($sformatf("bounce.press i%0d", i), prs_h, 1'b0);
            chk($sformatf("bounce.level i%0d", i), lvl_h, 1'b0);
        end
        pb_h = 1'b0;

        // ---- bounce during release: back to pressed with no strobe ----
        pb_h = 1'b1;
        for (int e = 0; e < 8; e++) begin
            step();
            chk($sformatf("rb_press e%0d", e), prs_h, (e == 6));
        end
        pb_h = 1'b0;
        step();
        step();
        pb_h = 1'b1;
        for (int e = 0; e < 8; e++) begin
            step();
            chk($sformatf("rb_hold.level e%0d", e), lvl_h, 1'b1);
            chk($sformatf("rb_hold.release e%0d", e), rel_h, 1'b0);
        end
        pb_h = 1'b0;
        for (int e = 0; e < 10; e++) begin
            step();
            chk($sformatf("rb_rel.release e%0d", e), rel_h, (e == 6));
            chk($sformatf("rb_rel.level e%0d", e), lvl_h, (e < 6));
        end

        // ---- case 4: active-low press and release ----
        pb_l = 1'b0;
        for (int e = 0; e < 10; e++) begin
            step();
            chk3($sformatf("al_press e%0d", e), lvl_l, prs_l, rel_l, (e >= 6), (e == 6), 1'b0);
        end
        pb_l = 1'b1;
        for (int e = 0; e < 10; e++) begin
            step();
            chk3($sformatf("al_release e%0d", e), lvl_l, prs_l, rel_l, (e < 6), 1'b0, (e == 6));
        end

        // ---- case 5a: reset while pressed, button still held ----
        pb_h = 1'b1;
        for (int e = 0; e < 8; e++) step();
        chk("rp_pre.level", lvl_h, 1'b1);
        @(posedge clk);
        #3;
        rst_a = 1'b1;
        #1;
        chk3("rp_async", lvl_h, prs_h, rel_h, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst_a = 1'b0;
        for (int e = 0; e < 10; e++) begin
            step();
            chk3($sformatf("rp_requal e%0d", e), lvl_h, prs_h, rel_h, (e >= 6), (e == 6), 1'b0);
        end
        pb_h = 1'b0;
        for (int e = 0; e < 10; e++) step();
        chk("rp_done.level", lvl_h, 1'b0);

        // ---- case 5b: reset mid-debounce at edge 4 ----
        pb_h = 1'b1;
        for (int e = 0; e < 4; e++) step();
        @(posedge clk);
        #3;
        rst_a = 1'b1;
        #1;
        chk3("md_async", lvl_h, prs_h, rel_h, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst_a = 1'b0;
        for (int e = 0; e < 10; e++) begin
            step();
            chk3($sformatf("md_requal e%0d", e), lvl_h, prs_h, rel_h, (e >= 6), (e == 6), 1'b0);
        end
        pb_h = 1'b0;
        for (int e = 0; e < 12; e++) step();
        chk("md_done.level", lvl_h, 1'b0);

        // ---- case 6: long hold, auto-repeat when enabled ----
        pb_h = 1'b1;
        for (int e = 0; e <= 30; e++) begin
            step();
`ifdef BUTTON_AUTOREPEAT_EN
            exp_p = (e == 6) || (e == 16) || (e == 19) || (e == 22) || (e == 25) || (e == 28);
`else
            exp_p = (e == 6);
`endif
            chk($sformatf("hold.press e%0d", e), prs_h, exp_p);
            chk($sformatf("hold.release e%0d", e), rel_h, 1'b0);
        end
        pb_h = 1'b0;
        for (int e = 0; e < 14; e++) step();
        chk("hold_done.level", lvl_h, 1'b0);
        chk("hold_done.press", prs_h, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/button_pulse_gen.md
Name: button_pulse_gen

Overview:
- Conditions one raw pushbutton/switch input into a clean debounced level plus single-cycle press and release strobes.
- Sits directly upstream of the BCD counter: its press strobe drives the counter's count-enable or clear input.
- Stages: 2-FF synchronizer, debounce FSM with stability counter, registered strobe outputs.
- One instance per physical button.

Parameters:
- DB_CYCLES, 500000, consecutive stable synchronized samples required to accept a press or release (10 ms at 50 MHz); legal range >= 2.
- ACTIVE_LOW, 0, 1 means the raw input is inverted before synchronizing (button pulls to ground).
- REPEAT_DELAY, 25000000, hold cycles before the first auto-repeat strobe; used only with AUTOREPEAT_EN.
- REPEAT_RATE, 5000000, cycles between later auto-repeat strobes; used only with AUTOREPEAT_EN.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst_a  input  1  asynchronous, active-high reset.
- p_b  input  1  raw, asynchronous, bouncing button input.
- p_b_level  output  1  debounced level; 1 means pressed.
- p_b_press  output  1  one-cycle strobe on an accepted press, and on each repeat.
- p_b_release  output  1  one-cycle strobe on an accepted release.

Behaviour:
- Reset: rst_a=1 immediately forces the following, independent of clk:
  - sync flops = 0 (the inactive level after ACTIVE_LOW inversion)
  - FSM = IDLE, counter = 0
  - p_b_level = 0, p_b_press = 0, p_b_release = 0
- Deassertion: after rst_a falls, the block resumes on the next clk edge. No strobe is generated from the reset state itself.
- Synchronizer: s1 <= p_b ^ ACTIVE_LOW; s2 <= s1. The FSM samples only s2.
- Counter width: $clog2 of the largest enabled count value, plus 1. It saturates and never wraps.
- FSM states and transitions:
  - IDLE: if s2=1, go to PRESS_WAIT and set cnt=0.
  - PRESS_WAIT:
    - if s2=0, return to IDLE and set cnt=0 (bounce rejected);
    - else if cnt==DB_CYCLES-1, go to PRESSED, set p_b_level=1 and p_b_press=1 for one cycle;
    - else cnt++.
  - PRESSED: if s2=0, go to RELEASE_WAIT and set cnt=0.
  - RELEASE_WAIT:
    - if s2=1, return to PRESSED; no strobe is issued and p_b_level stays 1;
    - else if cnt==DB_CYCLES-1, go to IDLE, set p_b_level=0 and p_b_release=1 for one cycle;
    - else cnt++.
- Latency: let edge 0 be the first edge that samples p_b active, with p_b held stable afterwards. The transition happens at edge 2+DB_CYCLES, so p_b_press is high during the cycle after that edge. Release latency is the same.
- Strobes are registered and last exactly one cycle. p_b_press and p_b_release are never high in the same cycle.
- p_b_level changes only in the cycle its strobe is asserted.
- Continuous bouncing faster than DB_CYCLES produces no strobes and no level change.
- Reset mid-debounce: the partial count is discarded and no strobe is issued.
- Reset while PRESSED: p_b_level drops to 0 with no release strobe. If the button is still held after reset, it is re-qualified as a fresh press.

Optional Feature:
- Macro: BUTTON_AUTOREPEAT_EN.
- Defined:
  - In PRESSED, a hold counter runs while s2=1.
  - p_b_press pulses once REPEAT_DELAY cycles after the initial press strobe, then every REPEAT_RATE cycles.
  - The hold counter clears on leaving PRESSED.
  - A bounce return from RELEASE_WAIT to PRESSED restarts the hold counter at 0 (full REPEAT_DELAY again).
- Undefined: exactly one press strobe per accepted press; the hold counter and the REPEAT_* parameters are absent from the netlist.

Test Plan:
Bench uses DB_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3.
1. Clean press: p_b 0->1 sampled at edge 0 and held -> p_b_press high only in the cycle after edge 6; p_b_level=1 from then on.
2. Bounce reject: p_b high for 3 cycles, low 2, high 3, then low -> no p_b_press; p_b_level stays 0.
3. Clean release: after case 1, p_b 1->0 held -> p_b_release one cycle, 6 edges later; p_b_level=0; p_b_press stays 0 throughout.
4. ACTIVE_LOW=1: p_b held at 0 -> same timing as case 1; p_b idle at 1 produces no strobes after reset.
5. Reset mid-operation: assert rst_a at edge 4 of a press, mid-clock -> all outputs 0 immediately. Release rst_a with p_b still held -> press strobe 6 edges after the first sampling edge.
6. With BUTTON_AUTOREPEAT_EN, hold p_b for 30 cycles -> press strobes in the cycles after edges 6, 16, 19, 22, 25, 28 (6+10, then every 3); without the macro -> a single strobe after edge 6.
